// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    INIT = 2'd3
  } state_t;

  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 3;
  localparam int CNT_W       = 4;
  localparam int DATA_W      = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data is registered and holds until the next read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: stalls the pipeline for LATENCY cycles per access.
// Optional build macro DMEM_RESET_CLEAR_EN zero-fills the array after reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int AW      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int IW = clog2(DEPTH);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, err_q;
  logic              req, accept, to_done;
  logic [IW-1:0]     arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_we, arr_re, acc_we;
  logic              unused_addr_bits;

  assign req = MemRead_i | MemWrite_i;
  assign unused_addr_bits = ^addr_i[AW-1:IW+2];

`ifdef DMEM_RESET_CLEAR_EN
  logic [IW-1:0] init_idx;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_o   = 1'b0;
    accept    = 1'b0;
    to_done   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          cnt_nxt = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = DONE;
            to_done   = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          to_done   = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
`ifdef DMEM_RESET_CLEAR_EN
      INIT: begin
        // Reset holds the walk at index 0 without stalling; the walk runs once rst_i drops.
        stall_o = ~rst_i;
        if (init_idx == IW'(DEPTH - 1)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the live inputs feed the array.
  always_comb begin
    acc_we    = (state == IDLE) ? MemWrite_i : we_q;
    arr_idx   = (state == IDLE) ? addr_i[IW+1:2] : idx_q;
    arr_wdata = (state == IDLE) ? data_i : wdata_q;
    arr_we    = ~rst_i & to_done & acc_we;
    arr_re    = ~rst_i & to_done & ~acc_we;
`ifdef DMEM_RESET_CLEAR_EN
    if (state == INIT) begin
      arr_idx   = init_idx;
      arr_wdata = '0;
      arr_we    = ~rst_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef DMEM_RESET_CLEAR_EN
      state    <= INIT;
      init_idx <= '0;
`else
      state    <= IDLE;
`endif
      cnt      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef DMEM_RESET_CLEAR_EN
      if (state == INIT) init_idx <= init_idx + IW'(1);
`endif
      if (accept) begin
        we_q  <= MemWrite_i;
        err_q <= (addr_i[1:0] != 2'b00) | (MemRead_i & MemWrite_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= addr_i[IW+1:2];
      wdata_q <= data_i;
    end
  end

  assign ack_o = (state == DONE);
  assign err_o = (state == DONE) & err_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (data_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, LATENCY=3).
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall, ack, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT),
    .AW      (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (rdata),
    .stall_o    (stall),
    .ack_o      (ack),
    .err_o      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access starting in the cycle after the previous one; ends in the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d,
                        input logic exp_err, input string tag);
    int n;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    chk({tag, ".ack_at_accept"}, 32'(ack), 32'd0);
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
      #1;
    end
    chk({tag, ".stalls"}, 32'(n), 32'(LAT));
    chk({tag, ".ack"}, 32'(ack), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".data"}, rdata, exp_d);
  endtask

  task automatic rst_release(input string tag);
    int n;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n = 0;
    while (stall && n < 1000) begin
      n++;
      @(posedge clk); #2;
    end
`ifdef DMEM_RESET_CLEAR_EN
    chk({tag, ".init_stalls"}, 32'(n), 32'(DEPTH));
`else
    chk({tag, ".init_stalls"}, 32'(n), 32'd0);
`endif
    chk({tag, ".ack_after_rst"}, 32'(ack), 32'd0);
  endtask

  initial begin
    logic [31:0] exp20;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.data", rdata, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst_release("rst1");

`ifdef DMEM_RESET_CLEAR_EN
    access(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'h0, 1'b0, "init_read_top");
`endif

    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr10");
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10_b2b");
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055, 32'hDEAD_BEEF, 1'b0, "wr400");
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0055, 1'b0, "rd0_wrap");
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1'b1, "rd13_misalign");
    access(1'b1, 1'b1, 32'h0000_0008, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, "conflict8");
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_1234, 1'b0, "rd8");
    access(1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_alias_hi");
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0, "wr20");

    // Store aborted by reset in its second stall cycle.
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_AAAA;
    #1;
    chk("abort.stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    mem_write = 1'b0; rst = 1'b1;
    #1;
    chk("abort.stall_busy", 32'(stall), 32'd1);
    @(posedge clk); #2;
    chk("abort.stall", 32'(stall), 32'd0);
    chk("abort.ack", 32'(ack), 32'd0);
    chk("abort.err", 32'(err), 32'd0);
    chk("abort.data", rdata, 32'd0);
    rst_release("rst2");

`ifdef DMEM_RESET_CLEAR_EN
    exp20 = 32'h0;
`else
    exp20 = 32'h1111_2222;
`endif
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, exp20, 1'b0, "rd20_after_abort");

    @(posedge clk); #2;
    chk("final.idle_ack", 32'(ack), 32'd0);
    chk("final.idle_stall", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
